// File: rtl/hamming_tx_scheduler.sv
// Two-requester round-robin front end for the (8,4) Hamming serial transmitter.
// Optional single-bit error injection is enabled by defining HAMMING_TX_ERR_INJECT_EN.
module hamming_tx_scheduler #(
    parameter int BIT_DIV = 4,
    parameter int CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_req0_valid,
    input  logic [3:0]       i_req0_data,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [3:0]       i_req1_data,
    output logic             o_req1_ready,
    output logic             o_tx_bit,
    output logic             o_tx_frame,
    output logic             o_tx_src,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_frame_cnt
`ifdef HAMMING_TX_ERR_INJECT_EN
    ,
    input  logic             i_err_inj,
    input  logic [2:0]       i_err_inj_pos
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [4:0] DIV_MAX = 5'(BIT_DIV - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_shreg;
    logic [4:0]         r_div_cnt;
    logic [2:0]         r_bit_cnt;
    logic               r_src;
    logic               r_ptr;
    logic [CNT_W-1:0]   r_frame_cnt;

    logic               w_grant1;
    logic               w_hs;
    logic               w_bit_end;
    logic               w_last_bit;
    logic [3:0]         w_nibble;
    logic [7:0]         w_cw;
    logic [7:0]         w_err_mask;
    logic [7:0]         w_cw_tx;

    // Requester 1 wins when it is alone or when the pointer favours it.
    assign w_grant1   = i_req1_valid & (~i_req0_valid | r_ptr);
    assign w_hs       = (r_state == ST_IDLE) & (i_req0_valid | i_req1_valid);
    assign w_nibble   = w_grant1 ? i_req1_data : i_req0_data;
    assign w_bit_end  = (r_div_cnt == DIV_MAX);
    assign w_last_bit = w_bit_end & (r_bit_cnt == 3'd7);

    assign w_cw = {w_nibble[0] ^ w_nibble[1] ^ w_nibble[2],
                   w_nibble[3], w_nibble[2], w_nibble[1],
                   w_nibble[1] ^ w_nibble[2] ^ w_nibble[3],
                   w_nibble[0],
                   w_nibble[0] ^ w_nibble[2] ^ w_nibble[3],
                   w_nibble[0] ^ w_nibble[1] ^ w_nibble[3]};

`ifdef HAMMING_TX_ERR_INJECT_EN
    assign w_err_mask = i_err_inj ? (8'd1 << i_err_inj_pos) : 8'd0;
`else
    assign w_err_mask = 8'd0;
`endif

    assign w_cw_tx     = w_cw ^ w_err_mask;
    assign o_tx_src    = r_src;
    assign o_frame_cnt = r_frame_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_tx_frame   = 1'b0;
        o_tx_bit     = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy       = 1'b0;
                o_req0_ready = i_req0_valid & ~w_grant1;
                o_req1_ready = w_grant1;
                if (w_hs) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_tx_frame = 1'b1;
                o_tx_bit   = r_shreg[7];
                if (w_last_bit) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                o_busy       = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_shreg     <= 8'd0;
            r_div_cnt   <= 5'd0;
            r_bit_cnt   <= 3'd0;
            r_src       <= 1'b0;
            r_ptr       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_hs) begin
                r_shreg   <= w_cw_tx;
                r_src     <= w_grant1;
                r_ptr     <= ~w_grant1;
                r_div_cnt <= 5'd0;
                r_bit_cnt <= 3'd0;
            end else if (r_state == ST_SHIFT) begin
                // Hold each bit for BIT_DIV cycles, then expose the next MSB.
                if (w_bit_end) begin
                    r_div_cnt <= 5'd0;
                    r_shreg   <= {r_shreg[6:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end else begin
                    r_div_cnt <= r_div_cnt + 5'd1;
                end
            end
            if (r_state == ST_GAP) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Bench for hamming_tx_scheduler: two instances (BIT_DIV=1 and BIT_DIV=4) share stimulus
// and are checked every cycle against a frame-timing reference model.
module tb_hamming_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [3:0] d0 = 4'd0, d1 = 4'd0;
`ifdef HAMMING_TX_ERR_INJECT_EN
    logic       err_inj = 1'b0;
    logic [2:0] err_pos = 3'd0;
`endif

    logic [1:0] rdy0_w, rdy1_w, bit_w, frame_w, src_w, busy_w, done_w;
    logic [7:0] cnt_w [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        hamming_tx_scheduler #(.BIT_DIV(gi == 0 ? 1 : 4), .CNT_W(8)) u_dut (
            .i_clk        (clk),
            .i_rstn       (rstn),
            .i_req0_valid (v0),
            .i_req0_data  (d0),
            .o_req0_ready (rdy0_w[gi]),
            .i_req1_valid (v1),
            .i_req1_data  (d1),
            .o_req1_ready (rdy1_w[gi]),
            .o_tx_bit     (bit_w[gi]),
            .o_tx_frame   (frame_w[gi]),
            .o_tx_src     (src_w[gi]),
            .o_busy       (busy_w[gi]),
            .o_done       (done_w[gi]),
            .o_frame_cnt  (cnt_w[gi])
`ifdef HAMMING_TX_ERR_INJECT_EN
            ,
            .i_err_inj    (err_inj),
            .i_err_inj_pos(err_pos)
`endif
        );
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: a frame is described by its handshake cycle and codeword.
    bit         m_busy  [2] = '{1'b0, 1'b0};
    int         m_start [2] = '{0, 0};
    logic [7:0] m_cw    [2] = '{8'd0, 8'd0};
    logic       m_src   [2] = '{1'b0, 1'b0};
    logic       m_ptr   [2] = '{1'b0, 1'b0};
    logic [7:0] m_cnt   [2] = '{8'd0, 8'd0};

    function automatic int bd(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic p3, p2, p1, p0;
        p3 = d[0] ^ d[1] ^ d[2];
        p2 = d[1] ^ d[2] ^ d[3];
        p1 = d[0] ^ d[2] ^ d[3];
        p0 = d[0] ^ d[1] ^ d[3];
        return {p3, d[3], d[2], d[1], p2, d[0], p1, p0};
    endfunction

    function automatic logic [7:0] inj_mask();
`ifdef HAMMING_TX_ERR_INJECT_EN
        logic [7:0] m;
        m = 8'd0;
        if (err_inj) m[err_pos] = 1'b1;
        return m;
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [1:0] model_ready(input int k);
        logic [1:0] r;
        r = 2'b00;
        if (!m_busy[k]) begin
            if (v0 && v1)  r[m_ptr[k]] = 1'b1;
            else if (v0)   r[0] = 1'b1;
            else if (v1)   r[1] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k]  <= 1'b0;
                m_start[k] <= 0;
                m_cw[k]    <= 8'd0;
                m_src[k]   <= 1'b0;
                m_ptr[k]   <= 1'b0;
                m_cnt[k]   <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [1:0] r;
                r = model_ready(k);
                if (!m_busy[k]) begin
                    if (r != 2'b00) begin
                        m_busy[k]  <= 1'b1;
                        m_start[k] <= cyc;
                        m_cw[k]    <= encode(r[1] ? d1 : d0) ^ inj_mask();
                        m_src[k]   <= r[1];
                        m_ptr[k]   <= ~r[1];
                    end
                end else if (cyc == m_start[k] + 8 * bd(k) + 1) begin
                    m_busy[k] <= 1'b0;
                    m_cnt[k]  <= m_cnt[k] + 8'd1;
                end
            end
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int e;
            logic ef, eb, ed;
            logic [1:0] r;
            e  = cyc - m_start[k];
            ef = m_busy[k] && (e >= 1) && (e <= 8 * bd(k));
            eb = 1'b0;
            if (ef) eb = m_cw[k][7 - (e - 1) / bd(k)];
            ed = m_busy[k] && (e == 8 * bd(k) + 1);
            r  = model_ready(k);
            check("mon_ready0", k, 32'(rdy0_w[k]), 32'(r[0]));
            check("mon_ready1", k, 32'(rdy1_w[k]), 32'(r[1]));
            check("mon_frame",  k, 32'(frame_w[k]), 32'(ef));
            check("mon_bit",    k, 32'(bit_w[k]), 32'(eb));
            check("mon_done",   k, 32'(done_w[k]), 32'(ed));
            check("mon_busy",   k, 32'(busy_w[k]), 32'(m_busy[k]));
            check("mon_src",    k, 32'(src_w[k]), 32'(m_src[k]));
            check("mon_cnt",    k, 32'(cnt_w[k]), 32'(m_cnt[k]));
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0; v0 = 1'b0; v1 = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic wait_ready(input int k, input int port);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((port == 0) ? rdy0_w[k] : rdy1_w[k]) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_timeout", k, 32'(ok), 32'd1);
    endtask

    // Returns at the negedge of the GAP cycle that follows the captured frame.
    task automatic capture(input int k, output logic [7:0] cw, output logic src, output int first);
        bit ok;
        ok = 1'b0;
        cw = 8'd0; src = 1'b0; first = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_w[k]) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_timeout", k, 32'(ok), 32'd1);
        if (ok) begin
            first = cyc;
            src   = src_w[k];
            for (int b = 0; b < 8; b++) begin
                cw[7 - b] = bit_w[k];
                repeat (bd(k)) @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_w[k]) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", k, 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [3:0] nib;
        logic [7:0] cw;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [7:0] cw_a, cw_b;
        logic       src_a, src_b;
        int         f_a, f_b;
        int         nf, n1, done_off;

        tbl[0] = '{4'hB, 8'h55};
        tbl[1] = '{4'h1, 8'h87};
        tbl[2] = '{4'h2, 8'h99};
        tbl[3] = '{4'h4, 8'hAA};
        tbl[4] = '{4'h8, 8'h4B};
        tbl[5] = '{4'h7, 8'hB4};
        tbl[6] = '{4'h0, 8'h00};
        tbl[7] = '{4'hF, 8'hFF};

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_frame", k, 32'(frame_w[k]), 32'd0);
            check("rst_busy",  k, 32'(busy_w[k]),  32'd0);
            check("rst_done",  k, 32'(done_w[k]),  32'd0);
            check("rst_src",   k, 32'(src_w[k]),   32'd0);
            check("rst_cnt",   k, 32'(cnt_w[k]),   32'd0);
        end

        // Table: encode each nibble on the BIT_DIV=1 instance.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            v0 = 1'b1; d0 = tbl[i].nib;
            wait_ready(0, 0);
            @(posedge clk); #1;
            v0 = 1'b0;
            capture(0, cw_a, src_a, f_a);
            check("tbl_cw",   0, 32'(cw_a), 32'(tbl[i].cw));
            check("tbl_src",  0, 32'(src_a), 32'd0);
            check("tbl_done", 0, 32'(done_w[0]), 32'd1);
            @(negedge clk);
            check("tbl_cnt",  0, 32'(cnt_w[0]), 32'(i + 1));
            wait_idle(1);
        end

        // Both requesters valid right after reset: requester 0 first.
        do_reset();
        v0 = 1'b1; d0 = 4'h1; v1 = 1'b1; d1 = 4'h2;
        capture(0, cw_a, src_a, f_a);
        capture(0, cw_b, src_b, f_b);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        check("rr_cw0",  0, 32'(cw_a), 32'h87);
        check("rr_src0", 0, 32'(src_a), 32'd0);
        check("rr_cw1",  0, 32'(cw_b), 32'h99);
        check("rr_src1", 0, 32'(src_b), 32'd1);
        check("rr_gap",  0, 32'(f_b - f_a), 32'd10);

        // Lone requester 1 granted back to back.
        do_reset();
        v1 = 1'b1; d1 = 4'hF;
        capture(0, cw_a, src_a, f_a);
        check("b2b_cw",  0, 32'(cw_a), 32'hFF);
        check("b2b_src", 0, 32'(src_a), 32'd1);
        for (int n = 0; n < 2; n++) begin
            capture(0, cw_b, src_b, f_b);
            check("b2b_cw",  0, 32'(cw_b), 32'hFF);
            check("b2b_src", 0, 32'(src_b), 32'd1);
            check("b2b_gap", 0, 32'(f_b - f_a), 32'd10);
            f_a = f_b;
        end
        @(posedge clk); #1;
        v1 = 1'b0;

        // BIT_DIV=4 instance, nibble 0: 32 frame cycles of zero, done at offset 33.
        do_reset();
        v0 = 1'b1; d0 = 4'h0;
        wait_ready(1, 0);
        @(posedge clk); #1;
        v0 = 1'b0;
        nf = 0; n1 = 0; done_off = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            nf += int'(frame_w[1]);
            n1 += int'(bit_w[1]);
            if (done_w[1]) done_off = i + 1;
        end
        check("div4_frame_len", 1, 32'(nf), 32'd32);
        check("div4_ones",      1, 32'(n1), 32'd0);
        check("div4_done_at",   1, 32'(done_off), 32'd33);
        check("div4_cnt",       1, 32'(cnt_w[1]), 32'd1);

        // Reset mid-frame aborts immediately and clears the frame count.
        @(posedge clk); #1;
        v0 = 1'b1; d0 = 4'hB;
        wait_ready(0, 0);
        @(posedge clk); #1;
        v0 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("abort_frame", k, 32'(frame_w[k]), 32'd0);
            check("abort_bit",   k, 32'(bit_w[k]),   32'd0);
            check("abort_busy",  k, 32'(busy_w[k]),  32'd0);
            check("abort_done",  k, 32'(done_w[k]),  32'd0);
            check("abort_src",   k, 32'(src_w[k]),   32'd0);
            check("abort_cnt",   k, 32'(cnt_w[k]),   32'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        v0 = 1'b1; d0 = 4'hB;
        wait_ready(0, 0);
        @(posedge clk); #1;
        v0 = 1'b0;
        capture(0, cw_a, src_a, f_a);
        check("after_abort_cw", 0, 32'(cw_a), 32'h55);
        @(negedge clk);
        check("after_abort_cnt", 0, 32'(cnt_w[0]), 32'd1);

`ifdef HAMMING_TX_ERR_INJECT_EN
        do_reset();
        err_inj = 1'b1; err_pos = 3'd3;
        v0 = 1'b1; d0 = 4'hB;
        wait_ready(0, 0);
        @(posedge clk); #1;
        v0 = 1'b0; err_inj = 1'b0;
        capture(0, cw_a, src_a, f_a);
        check("inj_cw", 0, 32'(cw_a), 32'h5D);
`endif

        // Random traffic, including valids withdrawn before any grant.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            d0 = 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
`ifdef HAMMING_TX_ERR_INJECT_EN
            err_inj = ($urandom_range(0, 7) == 0);
            err_pos = 3'($urandom_range(0, 7));
`endif
        end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
